// File: rtl/jpeg_bitstream_packer.sv
// Packs variable-length code fragments MSB-first into bytes, applies JPEG 0xFF->0xFF,0x00
// stuffing, pads the final partial byte with 1s on flush, and hands bytes out on valid/ready.
module jpeg_bitstream_packer #(
    parameter int FIFO_DEPTH  = 4,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [7:0]             in_bits,
    input  logic [3:0]             in_nbits,
    output logic                   in_ready,
    input  logic                   flush,
    output logic [7:0]             out_byte,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   flush_done,
    output logic [COUNT_WIDTH-1:0] byte_count
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_RUN, S_PAD, S_DRAIN} state_t;

    state_t        state;
    logic [15:0]   acc;
    logic [3:0]    acc_cnt;
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   fifo_cnt;
    logic          stuff_pending;

    logic [3:0]  n_eff, pad_n, cnt_base;
    logic [15:0] in_mask, frag, pad_mask;
    logic [7:0]  ext_byte;
    logic        fifo_full, fifo_empty, extract, accept;
    logic        out_hs, take, stuff_next, pop;

    always_comb begin
        n_eff      = (in_nbits > 4'd8) ? 4'd8 : in_nbits;
        in_mask    = (16'd1 << n_eff) - 16'd1;
        frag       = {8'h00, in_bits} & in_mask;
        fifo_full  = (fifo_cnt == FULL_CNT);
        fifo_empty = (fifo_cnt == '0);
        extract    = (acc_cnt >= 4'd8) && !fifo_full;
        // Oldest valid bit sits at acc[acc_cnt-1]; take the top 8 valid bits.
        ext_byte   = 8'(acc >> (acc_cnt - 4'd8));
        cnt_base   = extract ? (acc_cnt - 4'd8) : acc_cnt;
        pad_n      = 4'd8 - acc_cnt;
        pad_mask   = (16'd1 << pad_n) - 16'd1;
        in_ready   = !reset && (state == S_RUN) && ((acc_cnt < 4'd8) || extract);
        accept     = in_valid && in_ready;
        out_hs     = out_valid && out_ready;
        take       = !out_valid || out_ready;
        stuff_next = out_hs && !stuff_pending && (out_byte == 8'hFF);
        pop        = take && !stuff_next && !fifo_empty;
    end

    // Accumulator and flush sequencing
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_RUN;
            acc        <= '0;
            acc_cnt    <= '0;
            flush_done <= 1'b0;
        end else begin
            flush_done <= 1'b0;
            acc_cnt    <= cnt_base;
            if (accept) begin
                acc     <= (acc << n_eff) | frag;
                acc_cnt <= cnt_base + n_eff;
            end
            case (state)
                S_RUN: if (flush) state <= S_PAD;
                S_PAD: begin
                    // No accept or extract can coincide here: in_ready=0 and acc_cnt<8.
                    if (acc_cnt < 4'd8) begin
                        if (acc_cnt != 4'd0) begin
                            acc     <= (acc << pad_n) | pad_mask;
                            acc_cnt <= 4'd8;
                        end
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if ((acc_cnt == 4'd0) && fifo_empty && !out_valid) begin
                        flush_done <= 1'b1;
                        state      <= S_RUN;
                    end
                end
                default: state <= S_RUN;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (extract) fifo_mem[wr_ptr] <= ext_byte;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (extract) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            case ({extract, pop})
                2'b10:   fifo_cnt <= fifo_cnt + (PW+1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (PW+1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Output holding register; a delivered 0xFF is followed by an inserted 0x00.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid     <= 1'b0;
            out_byte      <= '0;
            stuff_pending <= 1'b0;
            byte_count    <= '0;
        end else begin
            if (out_hs) byte_count <= byte_count + COUNT_WIDTH'(1);
            if (take) begin
                if (stuff_next) begin
                    out_byte      <= 8'h00;
                    stuff_pending <= 1'b1;
                    out_valid     <= 1'b1;
                end else if (!fifo_empty) begin
                    out_byte      <= fifo_mem[rd_ptr];
                    stuff_pending <= 1'b0;
                    out_valid     <= 1'b1;
                end else begin
                    stuff_pending <= 1'b0;
                    out_valid     <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_jpeg_bitstream_packer.sv
// Directed bench for jpeg_bitstream_packer: expected bytes are queued at stimulus time
// and a free-running monitor pops and compares on every output handshake.
module tb_jpeg_bitstream_packer;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_bits = '0;
    logic [3:0]  in_nbits = '0;
    logic        in_ready;
    logic        flush = 1'b0;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        flush_done;
    logic [31:0] byte_count;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];

    jpeg_bitstream_packer #(.FIFO_DEPTH(4), .COUNT_WIDTH(32)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_bits(in_bits), .in_nbits(in_nbits), .in_ready(in_ready),
        .flush(flush),
        .out_byte(out_byte), .out_valid(out_valid), .out_ready(out_ready),
        .flush_done(flush_done), .byte_count(byte_count)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a handshake seen at negedge completes at the following posedge.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clock);
            if (!reset && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_byte: got %0h, expected no output", out_byte);
                end else begin
                    e = exp_q.pop_front();
                    check("out_byte", 32'(out_byte), 32'(e));
                end
            end
        end
    end

    task automatic send(input logic [7:0] b, input logic [3:0] n);
        int w = 0;
        in_valid = 1'b1;
        in_bits  = b;
        in_nbits = n;
        while (!in_ready && w < 200) begin
            @(posedge clock); #1;
            w++;
        end
        if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 500) begin
            @(posedge clock); #1;
            w++;
        end
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        repeat (2) begin @(posedge clock); #1; end
    endtask

    task automatic do_flush(output int lat);
        flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        check("in_ready_pad", 32'(in_ready), 32'd0);
        lat = 0;
        while (!flush_done && lat < 200) begin
            @(posedge clock); #1;
            lat++;
            if (!flush_done) check("in_ready_pad_drain", 32'(in_ready), 32'd0);
        end
        check("flush_done_seen", 32'(flush_done), 32'd1);
        @(posedge clock); #1;
        check("flush_done_pulse", 32'(flush_done), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock); #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_byte", 32'(out_byte), 32'd0);
        check("rst_flush_done", 32'(flush_done), 32'd0);
        check("rst_byte_count", byte_count, 32'd0);
        reset = 1'b0;
        @(posedge clock); #1;
        check("in_ready_after_reset", 32'(in_ready), 32'd1);
    endtask

    initial begin
        int lat;
        logic [7:0] t1 [8];
        t1 = '{8'd1, 8'd0, 8'd1, 8'd0, 8'd1, 8'd0, 8'd1, 8'd0};

        // 1: eight single-bit fragments form 0xAA
        do_reset();
        exp_q.push_back(8'hAA);
        for (int i = 0; i < 8; i++) send(t1[i], 4'd1);
        drain();
        check("t1_byte_count", byte_count, 32'd1);

        // 2: 0xFF is followed by a stuffed 0x00
        do_reset();
        exp_q.push_back(8'hFF); exp_q.push_back(8'h00); exp_q.push_back(8'h12);
        send(8'hFF, 4'd8);
        send(8'h12, 4'd8);
        drain();
        check("t2_byte_count", byte_count, 32'd3);

        // 3: 101 padded with ones -> 0xBF
        do_reset();
        exp_q.push_back(8'hBF);
        send(8'h05, 4'd3);
        do_flush(lat);
        drain();
        check("t3_byte_count", byte_count, 32'd1);

        // 4: seven ones padded to 0xFF, which is then stuffed
        do_reset();
        exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
        send(8'h7F, 4'd7);
        do_flush(lat);
        drain();
        check("t4_byte_count", byte_count, 32'd2);

        // Flush with nothing pending completes two cycles later
        do_flush(lat);
        check("empty_flush_latency", 32'(lat), 32'd2);
        check("empty_flush_no_bytes", byte_count, 32'd2);

        // 5: backpressure fills output register, FIFO and accumulator
        do_reset();
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) exp_q.push_back(8'(i * 17));
        for (int i = 1; i <= 6; i++) send(8'(i * 17), 4'd8);
        repeat (10) begin
            @(posedge clock); #1;
            check("t5_hold_valid", 32'(out_valid), 32'd1);
            check("t5_hold_byte", 32'(out_byte), 32'h11);
        end
        check("t5_in_ready_blocked", 32'(in_ready), 32'd0);
        check("t5_count_held", byte_count, 32'd0);
        out_ready = 1'b1;
        send(8'h77, 4'd8);
        send(8'h88, 4'd8);
        drain();
        check("t5_byte_count", byte_count, 32'd8);

        // 6: zero-length no-op, oversize length clamps to 8, reset mid-stream
        do_reset();
        exp_q.push_back(8'hA5);
        send(8'h3C, 4'd0);
        send(8'hA5, 4'd12);
        drain();
        check("t6_byte_count_a", byte_count, 32'd1);
        out_ready = 1'b0;
        send(8'h0B, 4'd4);
        send(8'h0C, 4'd4);
        send(8'h03, 4'd2);
        repeat (3) begin @(posedge clock); #1; end
        check("t6_pre_reset_valid", 32'(out_valid), 32'd1);
        check("t6_pre_reset_byte", 32'(out_byte), 32'hBC);
        reset = 1'b1;
        #1;
        check("t6_mid_reset_valid", 32'(out_valid), 32'd0);
        check("t6_mid_reset_count", byte_count, 32'd0);
        check("t6_mid_reset_ready", 32'(in_ready), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        out_ready = 1'b1;
        @(posedge clock); #1;
        check("t6_no_flush_done", 32'(flush_done), 32'd0);
        exp_q.push_back(8'h96);
        send(8'h09, 4'd4);
        send(8'h06, 4'd4);
        drain();
        check("t6_byte_count_b", byte_count, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
